hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl.sv | 106 ++++++++++
 tb/tb_hazard_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: groups the pipeline status inputs and stage-control
// outputs of the hazard controller. The master modport belongs to the pipeline
// (it drives status and receives controls). The slave modport belongs to
// hazard_ctrl.
interface hazard_ctrl_if;
    // Pipeline status seen by the hazard controller
    logic       ihit;
    logic       dmem_req;
    logic       dhit;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       ifid_uses_rt;
    logic       idex_DRen_o;
    logic [4:0] idex_rt_o;
    logic       ex_redirect;
    logic       idex_halt_o;
    // Stage controls produced by the hazard controller
    logic       pc_enable;
    logic       ifid_enable;
    logic       idex_enable;
    logic       ifid_flush;
    logic       idex_flush;
    logic       halted;

    modport master (
        output ihit, dmem_req, dhit, ifid_rs, ifid_rt, ifid_uses_rt,
               idex_DRen_o, idex_rt_o, ex_redirect, idex_halt_o,
        input  pc_enable, ifid_enable, idex_enable, ifid_flush, idex_flush, halted
    );

    modport slave (
        input  ihit, dmem_req, dhit, ifid_rs, ifid_rt, ifid_uses_rt,
               idex_DRen_o, idex_rt_o, ex_redirect, idex_halt_o,
        output pc_enable, ifid_enable, idex_enable, ifid_flush, idex_flush, halted
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller. It handles halt, data-memory
// freeze, control-flow flush and load-use stall.
// The three-state FSM (RUN, LDSTALL, HALT) is exposed on o_state for debug.
// All stage controls are combinational from the state and the inputs.
// Optional feature macro HAZARD_STATS_EN adds the saturating 32-bit counters
// o_stall_cnt (load-use bubbles) and o_flush_cnt (redirect flushes).
// Handshake note: there is no valid/ready pairing here. The pipeline presents
// its status every cycle. The enables and flushes are level signals, and the
// latches sample them on the same rising edge.
module hazard_ctrl (
    input  logic                 i_clk,
    input  logic                 i_rst,
    hazard_ctrl_if.slave         io_hz,
`ifdef HAZARD_STATS_EN
    output logic [31:0]          o_stall_cnt,
    output logic [31:0]          o_flush_cnt,
`endif
    output logic [1:0]           o_state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_freeze;
    logic   w_load_use;

    assign w_freeze   = io_hz.dmem_req & ~io_hz.dhit;
    // Register 0 is hard-wired zero, so a load into it never creates a hazard
    assign w_load_use = io_hz.idex_DRen_o && (io_hz.idex_rt_o != 5'd0) &&
                        ((io_hz.idex_rt_o == io_hz.ifid_rs) ||
                         (io_hz.ifid_uses_rt && (io_hz.idex_rt_o == io_hz.ifid_rt)));
    assign o_state    = r_state;

    // State register; reset forces RUN asynchronously
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_RUN;
        else       r_state <= w_next;
    end

    // Next state and stage controls, highest priority first
    always_comb begin
        w_next            = r_state;
        io_hz.pc_enable   = 1'b0;
        io_hz.ifid_enable = 1'b0;
        io_hz.idex_enable = 1'b0;
        io_hz.ifid_flush  = 1'b0;
        io_hz.idex_flush  = 1'b0;
        io_hz.halted      = 1'b0;
        if (i_rst) begin
            w_next = ST_RUN;
        end else if (r_state == ST_HALT) begin
            io_hz.halted = 1'b1;
        end else if (w_freeze) begin
            w_next = r_state;
        end else begin
            if (io_hz.ex_redirect) begin
                // Wrong-path fetch/decode discarded; any load-use match is moot
                io_hz.pc_enable   = 1'b1;
                io_hz.ifid_flush  = 1'b1;
                io_hz.idex_flush  = 1'b1;
                io_hz.idex_enable = 1'b1;
                w_next            = ST_RUN;
            end else if ((r_state == ST_RUN) && w_load_use && io_hz.ihit) begin
                // Hold PC and IF/ID, insert a bubble behind the load
                io_hz.idex_enable = 1'b1;
                io_hz.idex_flush  = 1'b1;
                w_next            = ST_LDSTALL;
            end else begin
                // Normal advance; a missing fetch becomes a bubble in ID/EX
                io_hz.pc_enable   = io_hz.ihit;
                io_hz.ifid_enable = io_hz.ihit;
                io_hz.idex_enable = 1'b1;
                io_hz.idex_flush  = ~io_hz.ihit;
                w_next            = ST_RUN;
            end
            if ((r_state == ST_RUN) && io_hz.idex_halt_o) w_next = ST_HALT;
        end
    end

`ifdef HAZARD_STATS_EN
    logic w_stall_ev;
    logic w_flush_ev;

    // A bubble with ihit=1 and no IF/ID flush occurs only on a load-use stall.
    // An IF/ID flush occurs only on a redirect. Freeze and HALT drive both to 0.
    assign w_stall_ev = io_hz.idex_flush & ~io_hz.ifid_flush & io_hz.ihit;
    assign w_flush_ev = io_hz.ifid_flush;

    // Saturating event counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stall_cnt <= 32'd0;
            o_flush_cnt <= 32'd0;
        end else begin
            if (w_stall_ev && (o_stall_cnt != 32'hFFFF_FFFF)) o_stall_cnt <= o_stall_cnt + 32'd1;
            if (w_flush_ev && (o_flush_cnt != 32'hFFFF_FFFF)) o_flush_cnt <= o_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl. The
// reference is a rule-level model of the pipeline mode (running, one-cycle
// load stall, halted) and of the event counts.
module tb_hazard_ctrl;
    logic       clk;
    logic       rst;
    logic [1:0] dut_state;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    hazard_ctrl_if hz ();

    hazard_ctrl dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .io_hz   (hz.slave),
`ifdef HAZARD_STATS_EN
        .o_stall_cnt (stall_cnt),
        .o_flush_cnt (flush_cnt),
`endif
        .o_state (dut_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = running, 1 = in load stall, 2 = halted
    int          m_mode = 0;
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_flush = 32'd0;

    function automatic logic model_load_use();
        if (!hz.idex_DRen_o || hz.idex_rt_o == 5'd0) return 1'b0;
        if (hz.idex_rt_o == hz.ifid_rs) return 1'b1;
        return hz.ifid_uses_rt && (hz.idex_rt_o == hz.ifid_rt);
    endfunction

    // Expected {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, halted}
    function automatic logic [5:0] model_out();
        if (rst) return 6'b000000;
        if (m_mode == 2) return 6'b000001;
        if (hz.dmem_req && !hz.dhit) return 6'b000000;
        if (hz.ex_redirect) return 6'b101110;
        if (m_mode == 0 && model_load_use() && hz.ihit) return 6'b001010;
        return {hz.ihit, hz.ihit, 1'b1, 1'b0, !hz.ihit, 1'b0};
    endfunction

    function automatic logic [5:0] dut_out();
        return {hz.pc_enable, hz.ifid_enable, hz.idex_enable,
                hz.ifid_flush, hz.idex_flush, hz.halted};
    endfunction

    // Advance the model across one rising edge with the current inputs
    task automatic model_edge();
        int was = m_mode;
        if (was == 2 || (hz.dmem_req && !hz.dhit)) return;
        if (hz.ex_redirect) begin
            if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
            m_mode = 0;
        end else if (was == 0 && model_load_use() && hz.ihit) begin
            if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            m_mode = 1;
        end else begin
            m_mode = 0;
        end
        if (was == 0 && hz.idex_halt_o) m_mode = 2;
    endtask

    task automatic check_outs(input string tag);
        logic [5:0] obs = dut_out();
        logic [5:0] exp = model_out();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
`ifdef HAZARD_STATS_EN
        checks++;
        assert (stall_cnt === m_stall) else begin
            errors++;
            $error("FAIL %s stall_cnt: observed %0d expected %0d", tag, stall_cnt, m_stall);
        end
        checks++;
        assert (flush_cnt === m_flush) else begin
            errors++;
            $error("FAIL %s flush_cnt: observed %0d expected %0d", tag, flush_cnt, m_flush);
        end
`endif
    endtask

    // Check this cycle's outputs mid-cycle, then step model and DUT together
    task automatic cycle(input string tag);
        @(negedge clk);
        check_outs(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        hz.ihit = 1'b1; hz.dmem_req = 1'b0; hz.dhit = 1'b0;
        hz.ifid_rs = 5'd0; hz.ifid_rt = 5'd0; hz.ifid_uses_rt = 1'b0;
        hz.idex_DRen_o = 1'b0; hz.idex_rt_o = 5'd0;
        hz.ex_redirect = 1'b0; hz.idex_halt_o = 1'b0;
    endtask

    // Mid-cycle asynchronous reset pulse, then the first post-reset cycle
    task automatic reset_pulse(input string tag);
        #2 rst = 1'b1;
        #1;
        m_mode = 0; m_stall = 32'd0; m_flush = 32'd0;
        check_outs({tag, "_in_reset"});
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outs({tag, "_post_reset"});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        set_idle();
        hz.ifid_rs = 5'd3; hz.idex_rt_o = 5'd3; hz.idex_DRen_o = 1'b1;
        rst = 1'b1;
        // Reset holds everything at zero, even across a clock edge
        #3 check_outs("reset_before_edge");
        @(posedge clk); #1;
        check_outs("reset_after_edge");
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        #1 check_outs("first_cycle_after_reset");
        @(posedge clk); model_edge(); #1;

        // Register zero never stalls
        hz.idex_DRen_o = 1'b1; hz.idex_rt_o = 5'd0; hz.ifid_rs = 5'd0;
        cycle("reg_zero_no_stall");

        // Load-use on rs: one bubble, then normal while the match persists
        hz.idex_rt_o = 5'd5; hz.ifid_rs = 5'd5;
        cycle("load_use_bubble");
        cycle("load_use_release");
        set_idle();
        cycle("after_load_use");

        // Load-use on rt only counts when rt is a source
        hz.idex_DRen_o = 1'b1; hz.idex_rt_o = 5'd7; hz.ifid_rt = 5'd7; hz.ifid_rs = 5'd1;
        hz.ifid_uses_rt = 1'b0;
        cycle("rt_unused_no_stall");
        hz.ifid_uses_rt = 1'b1;
        cycle("rt_used_stall");
        set_idle();
        cycle("rt_stall_exit");

        // Redirect overrides a matching load
        hz.idex_DRen_o = 1'b1; hz.idex_rt_o = 5'd9; hz.ifid_rs = 5'd9; hz.ex_redirect = 1'b1;
        cycle("redirect_with_load_use");
        set_idle();
        cycle("after_redirect");

        // Freeze during a load stall holds it; exits one cycle after dhit
        hz.idex_DRen_o = 1'b1; hz.idex_rt_o = 5'd4; hz.ifid_rs = 5'd4;
        cycle("stall_before_freeze");
        hz.dmem_req = 1'b1; hz.dhit = 1'b0;
        for (int i = 0; i < 3; i++) cycle("freeze_in_ldstall");
        hz.dhit = 1'b1;
        cycle("freeze_release");
        hz.dmem_req = 1'b0;
        cycle("back_in_run_restall");
        set_idle();

        // Fetch miss inserts a bubble
        hz.ihit = 1'b0;
        cycle("ihit_low_bubble");
        hz.ihit = 1'b1;

        // Halt is sticky until reset; reset clears it asynchronously
        hz.idex_halt_o = 1'b1;
        cycle("halt_seen");
        hz.idex_halt_o = 1'b0;
        cycle("halted_1");
        hz.ex_redirect = 1'b1; hz.dmem_req = 1'b1;
        cycle("halted_ignores_events");
        set_idle();
        reset_pulse("halt_reset");

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
                reset_pulse("rand_reset");
            end else begin
                hz.ihit         = ($urandom_range(0, 3) != 0);
                hz.dmem_req     = ($urandom_range(0, 3) == 0);
                hz.dhit         = $urandom_range(0, 1);
                hz.ifid_rs      = 5'($urandom_range(0, 3));
                hz.ifid_rt      = 5'($urandom_range(0, 3));
                hz.ifid_uses_rt = $urandom_range(0, 1);
                hz.idex_DRen_o  = $urandom_range(0, 1);
                hz.idex_rt_o    = 5'($urandom_range(0, 3));
                hz.ex_redirect  = ($urandom_range(0, 7) == 0);
                hz.idex_halt_o  = ($urandom_range(0, 24) == 0);
                cycle("random");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
